// File: rtl/mac_cfg_sequencer.sv
// mac_cfg_sequencer: power-up / reconfiguration sequencer for the Ethernet MAC and PHY.
// Walks a fixed register-write table, polls the command reset to completion, then enables Tx/Rx.
// A restart pulse or speed change aborts the run; a stalled slave raises a sticky timeout error.
module mac_cfg_sequencer #(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 32,
  parameter int          REAL_PHY = 1,
  parameter logic [31:0] MAC_HI   = 32'h06150910,
  parameter logic [31:0] MAC_LO   = 32'h2019,
  parameter logic [4:0]  PHY_ADDR = 5'h10,
  parameter int          POLL_BIT = 13,
  parameter int          TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        speed,
  input  logic              restart,
  input  logic              cfg_busy,
  input  logic [DATA_W-1:0] cfg_readdata,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_writedata,
  output logic              cfg_rd,
  output logic              cfg_wr,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [5:0]        cfg_step
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  // Last table entry is the command reset; without a real PHY the PHY block is skipped.
  localparam logic [5:0] LAST_STEP = (REAL_PHY != 0) ? 6'd17 : 6'd11;

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_WRITE, S_POLL, S_ENABLE, S_DONE, S_ERROR
  } state_t;

  state_t            r_state;
  logic [5:0]        r_step;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy_d;
  logic [1:0]        r_speed;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd;
  logic              r_wr;
  logic              r_done;
  logic              r_error;

  logic              w_cmp;
  logic              w_abort;
  logic              w_poll_set;
  logic              w_unused_rdata;
  logic [DATA_W-1:0] w_spd;
  logic [DATA_W-1:0] w_phyctl;
  logic [5:0]        w_nxt_step;
  logic [5:0]        w_tbl_idx;
  logic [ADDR_W-1:0] w_tbl_addr;
  logic [DATA_W-1:0] w_tbl_data;

  assign w_cmp          = !cfg_busy && r_busy_d;
  assign w_abort        = restart || (speed != r_speed);
  assign w_poll_set     = cfg_readdata[POLL_BIT];
  assign w_unused_rdata = ^cfg_readdata;
  assign w_nxt_step     = ((REAL_PHY == 0) && (r_step == 6'd10)) ? LAST_STEP : r_step + 6'd1;
  assign w_tbl_idx      = (r_state == S_WAIT_IDLE) ? 6'd0 : w_nxt_step;

  // Speed-dependent command-register bits and PHY control word.
  always_comb begin
    w_spd    = '0;
    w_phyctl = '0;
    case (r_speed)
      2'b00:   begin w_spd = DATA_W'(32'h0200_0000); w_phyctl = DATA_W'(32'h8100); end
      2'b01:   begin w_spd = '0;                     w_phyctl = DATA_W'(32'ha100); end
      default: begin w_spd = DATA_W'(32'h0000_0008); w_phyctl = DATA_W'(32'h8140); end
    endcase
  end

  // Register-write table lookup for the entry about to be issued.
  always_comb begin
    w_tbl_addr = '0;
    w_tbl_data = '0;
    if (w_tbl_idx == LAST_STEP) begin
      w_tbl_addr = ADDR_W'(8'h02);
      w_tbl_data = DATA_W'(32'h0400_2030) | w_spd;
    end else begin
      case (w_tbl_idx)
        6'd0:    begin w_tbl_addr = ADDR_W'(8'h03); w_tbl_data = DATA_W'(MAC_HI); end
        6'd1:    begin w_tbl_addr = ADDR_W'(8'h04); w_tbl_data = DATA_W'(MAC_LO); end
        6'd2:    begin w_tbl_addr = ADDR_W'(8'h09); w_tbl_data = DATA_W'(32'd500); end
        6'd3:    begin w_tbl_addr = ADDR_W'(8'h0a); w_tbl_data = DATA_W'(32'd100); end
        6'd4:    begin w_tbl_addr = ADDR_W'(8'h07); w_tbl_data = DATA_W'(32'd4000); end
        6'd5:    begin w_tbl_addr = ADDR_W'(8'h08); w_tbl_data = DATA_W'(32'd0); end
        6'd6:    begin w_tbl_addr = ADDR_W'(8'h0b); w_tbl_data = DATA_W'(32'd8); end
        6'd7:    begin w_tbl_addr = ADDR_W'(8'h0c); w_tbl_data = DATA_W'(32'd8); end
        6'd8:    begin w_tbl_addr = ADDR_W'(8'h0d); w_tbl_data = DATA_W'(32'd8); end
        6'd9:    begin w_tbl_addr = ADDR_W'(8'h0e); w_tbl_data = DATA_W'(32'd3); end
        6'd10:   begin w_tbl_addr = ADDR_W'(8'h0f); w_tbl_data = DATA_W'(PHY_ADDR); end
        6'd11:   begin w_tbl_addr = ADDR_W'(8'h84); w_tbl_data = DATA_W'(32'h0001); end
        6'd12:   begin w_tbl_addr = ADDR_W'(8'h89); w_tbl_data = DATA_W'(32'h0c00); end
        6'd13:   begin w_tbl_addr = ADDR_W'(8'h90); w_tbl_data = DATA_W'(32'ha078); end
        6'd14:   begin w_tbl_addr = ADDR_W'(8'h94); w_tbl_data = DATA_W'(32'h0ce2); end
        6'd15:   begin w_tbl_addr = ADDR_W'(8'h9b); w_tbl_data = DATA_W'(32'h848b); end
        6'd16:   begin w_tbl_addr = ADDR_W'(8'h80); w_tbl_data = w_phyctl; end
        default: begin w_tbl_addr = '0;             w_tbl_data = '0; end
      endcase
    end
  end

  // Sequencer FSM: abort wins over completion, timeout checked only when no completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_WAIT_IDLE;
      r_step   <= '0;
      r_cnt    <= '0;
      r_busy_d <= 1'b0;
      r_speed  <= speed;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_speed  <= speed;
      r_busy_d <= cfg_busy;
      if (w_abort) begin
        r_state  <= S_WAIT_IDLE;
        r_step   <= '0;
        r_cnt    <= '0;
        r_busy_d <= 1'b0;
        r_rd     <= 1'b0;
        r_wr     <= 1'b0;
        r_done   <= 1'b0;
        r_error  <= 1'b0;
      end else begin
        case (r_state)
          S_WAIT_IDLE: begin
            // Let any in-flight slave access drain before starting over.
            if (!cfg_busy) begin
              r_state <= S_WRITE;
              r_step  <= '0;
              r_cnt   <= '0;
              r_addr  <= w_tbl_addr;
              r_wdata <= w_tbl_data;
            end
          end
          S_WRITE, S_POLL, S_ENABLE: begin
            if (w_cmp) begin
              r_cnt <= '0;
              if (r_state == S_WRITE) begin
                if (r_step == LAST_STEP) begin
                  r_state <= S_POLL;
                  r_wr    <= 1'b0;
                  r_rd    <= 1'b1;
                  r_addr  <= ADDR_W'(8'h02);
                end else begin
                  r_wr    <= 1'b1;
                  r_step  <= w_nxt_step;
                  r_addr  <= w_tbl_addr;
                  r_wdata <= w_tbl_data;
                end
              end else if (r_state == S_POLL) begin
                if (!w_poll_set) begin
                  r_state <= S_ENABLE;
                  r_rd    <= 1'b0;
                  r_wr    <= 1'b1;
                  r_addr  <= ADDR_W'(8'h02);
                  r_wdata <= DATA_W'(32'h0400_0033) | w_spd;
                end
              end else begin
                r_state <= S_DONE;
                r_wr    <= 1'b0;
                r_done  <= 1'b1;
              end
            end else if (r_cnt == TO_VAL) begin
              r_state <= S_ERROR;
              r_cnt   <= '0;
              r_rd    <= 1'b0;
              r_wr    <= 1'b0;
              r_done  <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_state == S_WRITE) r_wr <= 1'b1;
            end
          end
          default: begin
            // DONE and ERROR hold until restart, speed change or reset.
            r_rd <= 1'b0;
            r_wr <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_addr      = r_addr;
  assign cfg_writedata = r_wdata;
  assign cfg_rd        = r_rd;
  assign cfg_wr        = r_wr;
  assign cfg_done      = r_done;
  assign cfg_error     = r_error;
  assign cfg_step      = r_step;

endmodule

// File: tb/tb_mac_cfg_sequencer.sv
// Bench for mac_cfg_sequencer: two instances (with / without PHY), TIMEOUT=100.
// A busy-for-two-cycles slave model accepts requests; each accepted request is
// checked against a queue of hand-computed expected transactions.
module tb_mac_cfg_sequencer;

  typedef struct packed {
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  speed   [2];
  logic        restart [2];
  logic        busy    [2];
  logic [31:0] rdata   [2];

  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        rd0, rd1, wr0, wr1, done0, done1, err0, err1;
  logic [5:0]  step0, step1;

  bit          sl_en      [2];
  int          sl_cnt     [2];
  logic        sl_rd      [2];
  int          rd_cnt     [2];
  int          poll_until [2];

  txn_t exp0[$];
  txn_t exp1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  wire [1:0] rd_v = {rd1, rd0};
  wire [1:0] wr_v = {wr1, wr0};

  mac_cfg_sequencer #(.REAL_PHY(1), .TIMEOUT(100)) u_phy (
    .clk(clk), .reset(reset), .speed(speed[0]), .restart(restart[0]),
    .cfg_busy(busy[0]), .cfg_readdata(rdata[0]),
    .cfg_addr(addr0), .cfg_writedata(wdata0), .cfg_rd(rd0), .cfg_wr(wr0),
    .cfg_done(done0), .cfg_error(err0), .cfg_step(step0)
  );

  mac_cfg_sequencer #(.REAL_PHY(0), .TIMEOUT(100)) u_nophy (
    .clk(clk), .reset(reset), .speed(speed[1]), .restart(restart[1]),
    .cfg_busy(busy[1]), .cfg_readdata(rdata[1]),
    .cfg_addr(addr1), .cfg_writedata(wdata1), .cfg_rd(rd1), .cfg_wr(wr1),
    .cfg_done(done1), .cfg_error(err1), .cfg_step(step1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic r, input logic [7:0] a, input logic [31:0] d);
    txn_t t;
    t.rd = r; t.addr = a; t.data = d;
    if (i == 0) exp0.push_back(t);
    else        exp1.push_back(t);
  endtask

  // Common MAC rows, plus the fixed PHY rows when a PHY is present.
  task automatic push_table(input int i, input bit phy);
    push(i, 0, 8'h03, 32'h06150910);
    push(i, 0, 8'h04, 32'h00002019);
    push(i, 0, 8'h09, 32'd500);
    push(i, 0, 8'h0a, 32'd100);
    push(i, 0, 8'h07, 32'd4000);
    push(i, 0, 8'h08, 32'd0);
    push(i, 0, 8'h0b, 32'd8);
    push(i, 0, 8'h0c, 32'd8);
    push(i, 0, 8'h0d, 32'd8);
    push(i, 0, 8'h0e, 32'd3);
    push(i, 0, 8'h0f, 32'h10);
    if (phy) begin
      push(i, 0, 8'h84, 32'h0001);
      push(i, 0, 8'h89, 32'h0c00);
      push(i, 0, 8'h90, 32'ha078);
      push(i, 0, 8'h94, 32'h0ce2);
      push(i, 0, 8'h9b, 32'h848b);
    end
  endtask

  // Monitor side: compare one accepted request with the head of its queue.
  task automatic check_txn(input int i, input logic r, input logic [7:0] a, input logic [31:0] d);
    txn_t e;
    n_cmp++;
    if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
      n_fail++;
      $display("FAIL txn%0d unexpected: got rd=%0b addr=%h data=%h expected none", i, r, a, d);
      return;
    end
    if (i == 0) e = exp0.pop_front();
    else        e = exp1.pop_front();
    if (r !== e.rd || a !== e.addr || (!r && d !== e.data)) begin
      n_fail++;
      $display("FAIL txn%0d: got rd=%0b addr=%h data=%h expected rd=%0b addr=%h data=%h",
               i, r, a, d, e.rd, e.addr, e.data);
    end
  endtask

  // Slave model: accept on request, busy for two cycles, poll bit set while below poll_until.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        busy[i]   = 1'b0;
        sl_cnt[i] = 0;
        sl_rd[i]  = 1'b0;
        rdata[i]  = 32'h0;
        rd_cnt[i] = 0;
      end else if (busy[i]) begin
        sl_cnt[i]--;
        if (sl_cnt[i] == 0) begin
          busy[i] = 1'b0;
          if (sl_rd[i]) begin
            rdata[i] = (rd_cnt[i] < poll_until[i]) ? 32'h0000_2000 : 32'h0;
            rd_cnt[i]++;
          end else begin
            rdata[i] = 32'h0;
          end
        end
      end else if (sl_en[i] && (rd_v[i] || wr_v[i])) begin
        busy[i]   = 1'b1;
        sl_cnt[i] = 2;
        sl_rd[i]  = rd_v[i];
        check_txn(i, rd_v[i], (i == 0) ? addr0 : addr1, (i == 0) ? wdata0 : wdata1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int i, input int lim);
    int n = 0;
    while (((i == 0) ? done0 : done1) !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    check($sformatf("done%0d_reached", i), (i == 0) ? done0 : done1, 1);
  endtask

  task automatic check_empty(input int i);
    check($sformatf("queue%0d_drained", i), (i == 0) ? exp0.size() : exp1.size(), 0);
  endtask

  task automatic pulse_restart(input int i);
    restart[i] = 1'b1;
    tick();
    restart[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    speed[0] = 2'b10;  speed[1] = 2'b00;
    restart[0] = 1'b0; restart[1] = 1'b0;
    sl_en[0] = 1'b1;   sl_en[1] = 1'b1;
    poll_until[0] = 0; poll_until[1] = 0;
    repeat (3) tick();

    // Reset state
    check("rst_addr", addr0, 0);
    check("rst_wdata", wdata0, 0);
    check("rst_rd", rd0, 0);
    check("rst_wr", wr0, 0);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    check("rst_step", step0, 0);
    check("rst_wr_nophy", wr1, 0);

    // 1000M with PHY; 10M without PHY
    push_table(0, 1);
    push(0, 0, 8'h80, 32'h8140);
    push(0, 0, 8'h02, 32'h04002038);
    push(0, 1, 8'h02, 32'h0);
    push(0, 0, 8'h02, 32'h0400003b);
    push_table(1, 0);
    push(1, 0, 8'h02, 32'h06002030);
    push(1, 1, 8'h02, 32'h0);
    push(1, 0, 8'h02, 32'h06000033);

    reset = 1'b0;
    tick();
    check("first_addr", addr0, 32'h3);
    check("first_data", wdata0, 32'h06150910);
    check("first_wr_low", wr0, 0);
    tick();
    check("wr_rise", wr0, 1);

    wait_done(0, 500);
    wait_done(1, 500);
    check("step_phy", step0, 17);
    check("step_nophy", step1, 11);
    check("done_rd", rd0, 0);
    check("done_wr", wr0, 0);
    check("done_err", err0, 0);
    check_empty(0);
    check_empty(1);

    // Timeout: slave ignores requests
    sl_en[1] = 1'b0;
    pulse_restart(1);
    check("to_done_clr", done1, 0);
    repeat (101) tick();
    check("to_err_before", err1, 0);
    tick();
    check("to_err_set", err1, 1);
    check("to_rd", rd1, 0);
    check("to_wr", wr1, 0);
    check("to_done", done1, 0);
    repeat (20) tick();
    check("to_err_sticky", err1, 1);
    push_table(1, 0);
    push(1, 0, 8'h02, 32'h06002030);
    push(1, 1, 8'h02, 32'h0);
    push(1, 0, 8'h02, 32'h06000033);
    sl_en[1] = 1'b1;
    pulse_restart(1);
    check("to_err_clr", err1, 0);
    wait_done(1, 500);
    check_empty(1);

    // Restart from DONE with poll bit held for 5 reads
    push_table(0, 1);
    push(0, 0, 8'h80, 32'h8140);
    push(0, 0, 8'h02, 32'h04002038);
    for (int k = 0; k < 6; k++) push(0, 1, 8'h02, 32'h0);
    push(0, 0, 8'h02, 32'h0400003b);
    poll_until[0] = rd_cnt[0] + 5;
    pulse_restart(0);
    check("rst_done_clr", done0, 0);
    wait_done(0, 800);
    check("poll_no_err", err0, 0);
    check_empty(0);

    // Speed change 10 -> 01 while a poll read is in flight
    push_table(0, 1);
    push(0, 0, 8'h80, 32'h8140);
    push(0, 0, 8'h02, 32'h04002038);
    push(0, 1, 8'h02, 32'h0);
    push_table(0, 1);
    push(0, 0, 8'h80, 32'ha100);
    push(0, 0, 8'h02, 32'h04002030);
    push(0, 1, 8'h02, 32'h0);
    push(0, 0, 8'h02, 32'h04000033);
    poll_until[0] = rd_cnt[0] + 5;
    pulse_restart(0);
    n = 0;
    while (!(rd0 === 1'b1 && busy[0] === 1'b1) && n < 500) begin
      tick();
      n++;
    end
    check("poll_inflight", {31'd0, rd0 & busy[0]}, 1);
    poll_until[0] = 0;
    speed[0] = 2'b01;
    tick();
    tick();
    check("spd_rd_drop", rd0, 0);
    check("spd_wr_drop", wr0, 0);
    check("spd_step_clr", step0, 0);
    wait_done(0, 800);
    check("spd_step_final", step0, 17);
    check_empty(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
